ami: RTL and testbench

- AXI4 master interface: the initiator counterpart of the team's AXI slave interface.
- Converts simple user write/read burst commands plus streaming data into AXI4 INCR bursts on the AW/W/B and AR/R channels.
- Sits between a user engine (DMA, testbench driver) and the interconnect.
- Write and read paths are independent. Each path has at most one burst outstanding.

---
 rtl/ami.sv | 258 +++++++++++++++++++++++++
 tb/tb_ami.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami.sv
// AXI4 master: turns user write/read burst commands into single
// outstanding INCR bursts on the AW/W/B and AR/R channels.
module ami #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_BRESPW = 2,
    parameter int AXI_RRESPW = 2,
    parameter int AMI_WID    = 0,
    parameter int AMI_RID    = 0,
    parameter int AXI_BYTES  = AXI_DW / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    output logic [AXI_IW-1:0]     AWID,
    output logic [AXI_AW-1:0]     AWADDR,
    output logic [AXI_LW-1:0]     AWLEN,
    output logic [AXI_SW-1:0]     AWSIZE,
    output logic [AXI_BURSTW-1:0] AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [AXI_DW-1:0]     WDATA,
    output logic [AXI_BYTES-1:0]  WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [AXI_IW-1:0]     BID,
    input  logic [AXI_BRESPW-1:0] BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [AXI_IW-1:0]     ARID,
    output logic [AXI_AW-1:0]     ARADDR,
    output logic [AXI_LW-1:0]     ARLEN,
    output logic [AXI_SW-1:0]     ARSIZE,
    output logic [AXI_BURSTW-1:0] ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [AXI_IW-1:0]     RID,
    input  logic [AXI_DW-1:0]     RDATA,
    input  logic [AXI_RRESPW-1:0] RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  usr_wcmd_valid,
    output logic                  usr_wcmd_ready,
    input  logic [AXI_AW-1:0]     usr_wcmd_addr,
    input  logic [AXI_LW-1:0]     usr_wcmd_len,
    input  logic [AXI_DW-1:0]     usr_wdata,
    input  logic [AXI_BYTES-1:0]  usr_wstrb,
    input  logic                  usr_wvalid,
    output logic                  usr_wready,
    output logic                  usr_wdone,
    output logic [1:0]            usr_wresp,
    input  logic                  usr_rcmd_valid,
    output logic                  usr_rcmd_ready,
    input  logic [AXI_AW-1:0]     usr_rcmd_addr,
    input  logic [AXI_LW-1:0]     usr_rcmd_len,
    output logic [AXI_DW-1:0]     usr_rdata,
    output logic                  usr_rvalid,
    output logic                  usr_rlast,
    input  logic                  usr_rready,
    output logic                  usr_rdone,
    output logic [1:0]            usr_rresp
);

    localparam int OFFW = $clog2(AXI_BYTES);

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP, W_DONE} wst_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rst_t;

    function automatic logic cross_4k(input logic [AXI_AW-1:0] a,
                                      input logic [AXI_LW-1:0] l);
        int unsigned span;
        span = 32'(a[11:0]) + (32'(l) + 32'd1) * 32'(AXI_BYTES);
        return span > 32'd4096;
    endfunction

    wst_t                  wst_q;
    logic [AXI_AW-1:0]     waddr_q;
    logic [AXI_LW-1:0]     wlen_q;
    logic [AXI_LW-1:0]     wbeat_q;
    logic                  awvalid_q;
    logic                  aw_done_q;
    logic                  wlast_done_q;
    logic                  bready_q;
    logic                  wdone_q;
    logic [1:0]            wresp_q;

    rst_t                  rst_q;
    logic [AXI_AW-1:0]     raddr_q;
    logic [AXI_LW-1:0]     rlen_q;
    logic [AXI_LW-1:0]     rbeat_q;
    logic                  arvalid_q;
    logic [1:0]            racc_q;
    logic                  rdone_q;
    logic [1:0]            rresp_q;

    logic w_act, w_hs, aw_hs, aw_ok, w_ok;
    logic r_act, r_hs;
    logic [1:0] racc_d;
    logic unused_id;

    assign unused_id = ^{BID, RID};

    assign AWID    = AXI_IW'(AMI_WID);
    assign AWADDR  = waddr_q;
    assign AWLEN   = wlen_q;
    assign AWSIZE  = AXI_SW'(OFFW);
    assign AWBURST = AXI_BURSTW'(1);
    assign AWVALID = awvalid_q;
    assign BREADY  = bready_q;

    // W beats stream straight through while the burst still owes data
    assign w_act      = (wst_q == W_BURST) && !wlast_done_q;
    assign WVALID     = usr_wvalid & w_act;
    assign usr_wready = WREADY & w_act;
    assign WDATA      = usr_wdata;
    assign WSTRB      = usr_wstrb;
    assign WLAST      = w_act && (wbeat_q == wlen_q);
    assign w_hs       = WVALID & WREADY;
    assign aw_hs      = awvalid_q & AWREADY;
    assign aw_ok      = aw_done_q | aw_hs;
    assign w_ok       = wlast_done_q | (w_hs & WLAST);

    assign usr_wcmd_ready = (wst_q == W_IDLE);
    assign usr_wdone      = wdone_q;
    assign usr_wresp      = wresp_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wst_q        <= W_IDLE;
            waddr_q      <= '0;
            wlen_q       <= '0;
            wbeat_q      <= '0;
            awvalid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            wlast_done_q <= 1'b0;
            bready_q     <= 1'b0;
            wdone_q      <= 1'b0;
            wresp_q      <= 2'b00;
        end else begin
            wdone_q <= 1'b0;
            unique case (wst_q)
                W_IDLE: if (usr_wcmd_valid) begin
                    waddr_q      <= {usr_wcmd_addr[AXI_AW-1:OFFW], OFFW'(0)};
                    wlen_q       <= usr_wcmd_len;
                    wbeat_q      <= '0;
                    aw_done_q    <= 1'b0;
                    wlast_done_q <= 1'b0;
                    if (cross_4k(usr_wcmd_addr, usr_wcmd_len)) begin
                        wst_q   <= W_DONE;
                        wdone_q <= 1'b1;
                        wresp_q <= 2'b10;
                    end else begin
                        wst_q     <= W_BURST;
                        awvalid_q <= 1'b1;
                    end
                end
                W_BURST: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wbeat_q <= wbeat_q + 1'b1;
                        if (WLAST) wlast_done_q <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        wst_q    <= W_RESP;
                        bready_q <= 1'b1;
                    end
                end
                W_RESP: if (BVALID) begin
                    wresp_q  <= BRESP;
                    bready_q <= 1'b0;
                    wdone_q  <= 1'b1;
                    wst_q    <= W_DONE;
                end
                W_DONE: wst_q <= W_IDLE;
                default: wst_q <= W_IDLE;
            endcase
        end
    end

    assign ARID    = AXI_IW'(AMI_RID);
    assign ARADDR  = raddr_q;
    assign ARLEN   = rlen_q;
    assign ARSIZE  = AXI_SW'(OFFW);
    assign ARBURST = AXI_BURSTW'(1);
    assign ARVALID = arvalid_q;

    assign r_act      = (rst_q == R_DATA);
    assign usr_rdata  = RDATA;
    assign usr_rlast  = RLAST;
    assign usr_rvalid = RVALID & r_act;
    assign RREADY     = usr_rready & r_act;
    assign r_hs       = RVALID & RREADY;
    assign racc_d     = (RRESP > racc_q) ? RRESP : racc_q;

    assign usr_rcmd_ready = (rst_q == R_IDLE);
    assign usr_rdone      = rdone_q;
    assign usr_rresp      = rresp_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rst_q     <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            arvalid_q <= 1'b0;
            racc_q    <= 2'b00;
            rdone_q   <= 1'b0;
            rresp_q   <= 2'b00;
        end else begin
            rdone_q <= 1'b0;
            unique case (rst_q)
                R_IDLE: if (usr_rcmd_valid) begin
                    raddr_q <= {usr_rcmd_addr[AXI_AW-1:OFFW], OFFW'(0)};
                    rlen_q  <= usr_rcmd_len;
                    rbeat_q <= '0;
                    racc_q  <= 2'b00;
                    if (cross_4k(usr_rcmd_addr, usr_rcmd_len)) begin
                        rst_q   <= R_DONE;
                        rdone_q <= 1'b1;
                        rresp_q <= 2'b10;
                    end else begin
                        rst_q     <= R_ADDR;
                        arvalid_q <= 1'b1;
                    end
                end
                R_ADDR: if (ARREADY) begin
                    arvalid_q <= 1'b0;
                    rst_q     <= R_DATA;
                end
                // Early RLAST or a missing RLAST both close as SLVERR
                R_DATA: if (r_hs) begin
                    rbeat_q <= rbeat_q + 1'b1;
                    racc_q  <= racc_d;
                    if (RLAST) begin
                        rst_q   <= R_DONE;
                        rdone_q <= 1'b1;
                        rresp_q <= (rbeat_q != rlen_q) ? 2'b10 : racc_d;
                    end else if (rbeat_q == rlen_q) begin
                        rst_q   <= R_DONE;
                        rdone_q <= 1'b1;
                        rresp_q <= 2'b10;
                    end
                end
                R_DONE: rst_q <= R_IDLE;
                default: rst_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ami.sv
// Directed bench for ami: small AXI slave behaviour driven inline,
// expected values hand-computed from the burst parameters.
module tb_ami;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [7:0]    AWID;
    logic [39:0]   AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWVALID;
    logic          AWREADY;
    logic [127:0]  WDATA;
    logic [15:0]   WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [7:0]    BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [7:0]    ARID;
    logic [39:0]   ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [7:0]    RID;
    logic [127:0]  RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          usr_wcmd_valid;
    logic          usr_wcmd_ready;
    logic [39:0]   usr_wcmd_addr;
    logic [7:0]    usr_wcmd_len;
    logic [127:0]  usr_wdata;
    logic [15:0]   usr_wstrb;
    logic          usr_wvalid;
    logic          usr_wready;
    logic          usr_wdone;
    logic [1:0]    usr_wresp;
    logic          usr_rcmd_valid;
    logic          usr_rcmd_ready;
    logic [39:0]   usr_rcmd_addr;
    logic [7:0]    usr_rcmd_len;
    logic [127:0]  usr_rdata;
    logic          usr_rvalid;
    logic          usr_rlast;
    logic          usr_rready;
    logic          usr_rdone;
    logic [1:0]    usr_rresp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ami dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
        .BREADY(BREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .usr_wcmd_valid(usr_wcmd_valid), .usr_wcmd_ready(usr_wcmd_ready),
        .usr_wcmd_addr(usr_wcmd_addr), .usr_wcmd_len(usr_wcmd_len),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
        .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
        .usr_wdone(usr_wdone), .usr_wresp(usr_wresp),
        .usr_rcmd_valid(usr_rcmd_valid), .usr_rcmd_ready(usr_rcmd_ready),
        .usr_rcmd_addr(usr_rcmd_addr), .usr_rcmd_len(usr_rcmd_len),
        .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
        .usr_rlast(usr_rlast), .usr_rready(usr_rready),
        .usr_rdone(usr_rdone), .usr_rresp(usr_rresp)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [39:0] addr, input logic [7:0] len,
                            input int aw_delay, output int beats,
                            output int done_cyc, output logic [1:0] resp);
        int guard = 0;
        int ahs = 0;
        bit hs;
        usr_wcmd_valid = 1'b1;
        usr_wcmd_addr  = addr;
        usr_wcmd_len   = len;
        tick();
        usr_wcmd_valid = 1'b0;
        check("aw_valid", AWVALID, 1'b1);
        check("aw_addr", AWADDR, addr & ~40'hF);
        check("aw_len", AWLEN, len);
        check("aw_size", AWSIZE, 3'd4);
        check("aw_burst", AWBURST, 2'b01);
        check("wcmd_busy", usr_wcmd_ready, 1'b0);
        beats = 0;
        while (!BREADY && guard < 2000) begin
            AWREADY    = (guard >= aw_delay);
            WREADY     = 1'b1;
            usr_wvalid = 1'b1;
            usr_wdata  = 128'(beats) + 128'h5A00;
            usr_wstrb  = '1;
            #1;
            if (guard > 0 && guard < aw_delay)
                check("aw_hold", AWVALID, 1'b1);
            hs = WVALID && WREADY;
            if (hs) begin
                check("wdata", WDATA, 128'(beats) + 128'h5A00);
                check("wlast", WLAST, beats == int'(len));
            end
            if (AWVALID && AWREADY) ahs++;
            tick();
            if (hs) beats++;
            guard++;
        end
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        usr_wvalid = 1'b0;
        check("w_reach_resp", BREADY, 1'b1);
        check("aw_count", ahs, 1);
        BVALID = 1'b1;
        BRESP  = 2'b00;
        tick();
        BVALID = 1'b0;
        check("wdone_pulse", usr_wdone, 1'b1);
        done_cyc = cyc;
        resp = usr_wresp;
        tick();
        check("wdone_one", usr_wdone, 1'b0);
    endtask

    task automatic do_read(input logic [39:0] addr, input logic [7:0] len,
                           input int rlast_at, input int err_at,
                           input bit toggle, output int beats,
                           output int done_cyc, output logic [1:0] resp);
        int guard = 0;
        bit hs;
        usr_rcmd_valid = 1'b1;
        usr_rcmd_addr  = addr;
        usr_rcmd_len   = len;
        tick();
        usr_rcmd_valid = 1'b0;
        check("ar_valid", ARVALID, 1'b1);
        check("ar_addr", ARADDR, addr & ~40'hF);
        check("ar_len", ARLEN, len);
        check("ar_size", ARSIZE, 3'd4);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        check("ar_drop", ARVALID, 1'b0);
        beats = 0;
        while (!usr_rdone && guard < 300) begin
            RVALID     = 1'b1;
            RDATA      = 128'(beats) + 128'hA0;
            RLAST      = (beats == rlast_at);
            RRESP      = (beats == err_at) ? 2'b10 : 2'b00;
            usr_rready = toggle ? guard[0] : 1'b1;
            #1;
            hs = usr_rvalid && usr_rready;
            if (hs) begin
                check("rready", RREADY, 1'b1);
                check("rdata", usr_rdata, 128'(beats) + 128'hA0);
                check("rlast", usr_rlast, beats == rlast_at);
            end
            tick();
            if (hs) beats++;
            guard++;
        end
        RVALID     = 1'b0;
        RLAST      = 1'b0;
        usr_rready = 1'b0;
        check("rdone_seen", usr_rdone, 1'b1);
        done_cyc = cyc;
        resp = usr_rresp;
        tick();
        check("rdone_one", usr_rdone, 1'b0);
    endtask

    initial begin
        int wb, rb, wdc, rdc;
        logic [1:0] wr, rr;
        bit seen;
        ARESETn = 1'b0;
        AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
        ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
        usr_wcmd_valid = 0; usr_wcmd_addr = 0; usr_wcmd_len = 0;
        usr_wdata = 0; usr_wstrb = 0; usr_wvalid = 0;
        usr_rcmd_valid = 0; usr_rcmd_addr = 0; usr_rcmd_len = 0;
        usr_rready = 0;
        tick();
        tick();
        check("rst_awvalid", AWVALID, 1'b0);
        check("rst_arvalid", ARVALID, 1'b0);
        check("rst_bready", BREADY, 1'b0);
        check("rst_wdone", usr_wdone, 1'b0);
        check("rst_rdone", usr_rdone, 1'b0);
        check("rst_wresp", usr_wresp, 2'b00);
        check("rst_rresp", usr_rresp, 2'b00);
        check("rst_wcmd_rdy", usr_wcmd_ready, 1'b1);
        check("rst_rcmd_rdy", usr_rcmd_ready, 1'b1);
        ARESETn = 1'b1;
        tick();

        do_write(40'h1000, 8'd3, 5, wb, wdc, wr);
        check("w1_beats", wb, 4);
        check("w1_resp", wr, 2'b00);

        usr_wcmd_valid = 1'b1;
        usr_wcmd_addr  = 40'h0F80;
        usr_wcmd_len   = 8'd15;
        usr_wvalid     = 1'b1;
        WREADY         = 1'b1;
        tick();
        usr_wcmd_valid = 1'b0;
        check("w4k_done", usr_wdone, 1'b1);
        check("w4k_resp", usr_wresp, 2'b10);
        check("w4k_awvalid", AWVALID, 1'b0);
        check("w4k_wvalid", WVALID, 1'b0);
        check("w4k_wready", usr_wready, 1'b0);
        tick();
        check("w4k_done_one", usr_wdone, 1'b0);
        check("w4k_idle", usr_wcmd_ready, 1'b1);
        usr_wvalid = 1'b0;
        WREADY     = 1'b0;

        do_read(40'h2008, 8'd7, 7, 99, 1'b1, rb, rdc, rr);
        check("r1_beats", rb, 8);
        check("r1_resp", rr, 2'b00);

        do_read(40'h2100, 8'd7, 4, 99, 1'b0, rb, rdc, rr);
        check("r_early_beats", rb, 5);
        check("r_early_resp", rr, 2'b10);

        do_read(40'h2200, 8'd3, 3, 1, 1'b0, rb, rdc, rr);
        check("r_err_beats", rb, 4);
        check("r_err_resp", rr, 2'b10);

        do_read(40'h2300, 8'd2, 99, 99, 1'b0, rb, rdc, rr);
        check("r_nolast_beats", rb, 3);
        check("r_nolast_resp", rr, 2'b10);

        fork
            do_write(40'h0, 8'd255, 0, wb, wdc, wr);
            do_read(40'h100, 8'd0, 0, 99, 1'b0, rb, rdc, rr);
        join
        check("cc_wbeats", wb, 256);
        check("cc_wresp", wr, 2'b00);
        check("cc_rbeats", rb, 1);
        check("cc_rresp", rr, 2'b00);
        check("cc_order", rdc < wdc, 1'b1);

        usr_wcmd_valid = 1'b1;
        usr_wcmd_addr  = 40'h3000;
        usr_wcmd_len   = 8'd3;
        tick();
        usr_wcmd_valid = 1'b0;
        usr_wvalid     = 1'b1;
        WREADY         = 1'b1;
        usr_wdata      = 128'h77;
        tick();
        ARESETn = 1'b0;
        tick();
        check("mr_awvalid", AWVALID, 1'b0);
        check("mr_wvalid", WVALID, 1'b0);
        check("mr_wcmd_rdy", usr_wcmd_ready, 1'b1);
        ARESETn    = 1'b1;
        usr_wvalid = 1'b0;
        WREADY     = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (usr_wdone) seen = 1'b1;
            tick();
        end
        check("mr_no_done", seen, 1'b0);
        do_write(40'h3040, 8'd1, 2, wb, wdc, wr);
        check("mr_new_beats", wb, 2);
        check("mr_new_resp", wr, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
